// File: rtl/call_return_pkg.sv
// Shared op/state encodings and default geometry for the call/return sequencer.
// No logic; imported by every file of the block.
package call_return_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_JMP  = 3'd1,
      OP_BRZ  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4,
      OP_HALT = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   localparam int CR_ADDR_W   = 11;
   localparam int CR_DEPTH    = 16;
   localparam int CR_RESET_PC = 'h000;

endpackage

// File: rtl/call_return_ctrl_next_pc.sv
// cr_next_pc: combinational flow-op decode -> next pc, push/pop strobes, next depth.
// Latency: zero (pure combinational). Optional CR_STACK_GUARD_EN turns over/underflow into a fault request.
// Backpressure: none; strobes are only raised when exec is high.
module cr_next_pc
   import call_return_pkg::*;
#(
   parameter int ADDR_W = CR_ADDR_W,
   parameter int DEPTH  = CR_DEPTH
) (
   input  logic                     exec,
   input  logic [2:0]               op,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [ADDR_W-1:0]        target,
   input  logic                     zero_flag,
   input  logic [ADDR_W-1:0]        stk_data_in,
   input  logic [$clog2(DEPTH):0]   depth,
   output logic [ADDR_W-1:0]        next_pc,
   output logic                     push,
   output logic                     pop,
   output logic [$clog2(DEPTH):0]   depth_next,
   output logic                     halt_req,
   output logic                     fault_req
);

   localparam int DW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc_inc;
   logic              stack_full;
   logic              stack_empty;
   logic [DW-1:0]     depth_inc;
   logic [DW-1:0]     depth_dec;

   assign pc_inc = pc + ADDR_W'(1);

`ifdef CR_STACK_GUARD_EN
   assign stack_full  = (depth == DW'(DEPTH));
   assign stack_empty = (depth == '0);
   assign depth_inc   = depth + DW'(1);
   assign depth_dec   = depth - DW'(1);
`else
   // Unguarded: depth follows the stack pointer, which wraps mod DEPTH.
   assign stack_full  = 1'b0;
   assign stack_empty = 1'b0;
   assign depth_inc   = (depth == DW'(DEPTH - 1)) ? '0 : depth + DW'(1);
   assign depth_dec   = (depth == '0) ? DW'(DEPTH - 1) : depth - DW'(1);
`endif

   always_comb begin
      next_pc    = pc;
      push       = 1'b0;
      pop        = 1'b0;
      depth_next = depth;
      halt_req   = 1'b0;
      fault_req  = 1'b0;
      if (exec) begin
         case (op)
            OP_JMP:  next_pc = target;
            OP_BRZ:  next_pc = zero_flag ? target : pc_inc;
            OP_CALL: begin
               if (stack_full) begin
                  fault_req = 1'b1;
               end else begin
                  push       = 1'b1;
                  next_pc    = target;
                  depth_next = depth_inc;
               end
            end
            OP_RET: begin
               if (stack_empty) begin
                  fault_req = 1'b1;
               end else begin
                  pop        = 1'b1;
                  next_pc    = stk_data_in;
                  depth_next = depth_dec;
               end
            end
            OP_HALT: halt_req = 1'b1;
            default: next_pc  = pc_inc;
         endcase
      end
   end

endmodule

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: PC owner and return-stack initiator; CR_STACK_GUARD_EN enables over/underflow fault.
// Latency: one op per cycle, new pc visible the cycle after exec; push/pop are same-cycle strobes.
// Backpressure: instr_valid=0 or run_en=0 stalls with pc/depth held; HALT/FAULT leave only via reset.
module call_return_ctrl
   import call_return_pkg::*;
#(
   parameter int                ADDR_W   = CR_ADDR_W,
   parameter int                DEPTH    = CR_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CR_RESET_PC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run_en,
   input  logic                     instr_valid,
   input  logic [2:0]               op,
   input  logic [ADDR_W-1:0]        target,
   input  logic                     zero_flag,
   input  logic [ADDR_W-1:0]        stk_data_in,
   output logic [ADDR_W-1:0]        pc,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic [ADDR_W-1:0]        stk_data_out,
   output logic [$clog2(DEPTH):0]   depth,
   output logic [1:0]               state,
   output logic                     fault
);

   localparam int DW = $clog2(DEPTH) + 1;

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [DW-1:0]     depth_q;
   logic              exec;
   logic [ADDR_W-1:0] next_pc;
   logic [DW-1:0]     depth_next;
   logic              push;
   logic              pop;
   logic              halt_req;
   logic              fault_req;

   // Reset gates exec so an op presented in the reset cycle never strobes the stack.
   assign exec = (state_q == ST_RUN) && run_en && instr_valid && !reset;

   cr_next_pc #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_next_pc (
      .exec        (exec),
      .op          (op),
      .pc          (pc_q),
      .target      (target),
      .zero_flag   (zero_flag),
      .stk_data_in (stk_data_in),
      .depth       (depth_q),
      .next_pc     (next_pc),
      .push        (push),
      .pop         (pop),
      .depth_next  (depth_next),
      .halt_req    (halt_req),
      .fault_req   (fault_req)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (run_en) state_d = ST_RUN;
         ST_RUN: begin
            if (fault_req) begin
               state_d = ST_FAULT;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end else if (!run_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         depth_q <= '0;
      end else if (exec) begin
         pc_q    <= next_pc;
         depth_q <= depth_next;
      end
   end

`ifdef CR_STACK_GUARD_EN
   logic fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (fault_req) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign pc           = pc_q;
   assign depth        = depth_q;
   assign state        = state_q;
   assign stk_push     = push;
   assign stk_pop      = pop;
   assign stk_data_out = pc_q + ADDR_W'(1);

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_call_return_ctrl;
   import call_return_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_en = 1'b0;
   logic        instr_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [10:0] target = '0;
   logic        zero_flag = 1'b0;
   logic [10:0] stk_data_in = '0;
   logic [10:0] pc;
   logic        stk_push;
   logic        stk_pop;
   logic [10:0] stk_data_out;
   logic [4:0]  depth;
   logic [1:0]  state;
   logic        fault;

   always #5 clk = ~clk;

   call_return_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .run_en       (run_en),
      .instr_valid  (instr_valid),
      .op           (op),
      .target       (target),
      .zero_flag    (zero_flag),
      .stk_data_in  (stk_data_in),
      .pc           (pc),
      .stk_push     (stk_push),
      .stk_pop      (stk_pop),
      .stk_data_out (stk_data_out),
      .depth        (depth),
      .state        (state),
      .fault        (fault)
   );

   typedef struct {
      int          tag;
      logic [10:0] pc;
      logic        push;
      logic        pop;
      logic [4:0]  depth;
      logic [1:0]  state;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   int   tests = 0;
   int   fails = 0;
   int   tag = 0;

   // Drive one cycle of inputs and queue what the outputs must show during that cycle.
   task automatic cyc(input logic rst, input logic r, input logic v, input logic [2:0] o,
                      input logic [10:0] tg, input logic zf, input logic [10:0] sdi,
                      input logic [10:0] e_pc, input logic e_push, input logic e_pop,
                      input logic [4:0] e_d, input logic [1:0] e_s, input logic e_f);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; run_en = r; instr_valid = v; op = o;
      target = tg; zero_flag = zf; stk_data_in = sdi;
      e.tag = tag; e.pc = e_pc; e.push = e_push; e.pop = e_pop;
      e.depth = e_d; e.state = e_s; e.fault = e_f;
      exp_q.push_back(e);
      tag++;
   endtask

   task automatic ex(input logic [2:0] o, input logic [10:0] tg, input logic zf, input logic [10:0] sdi,
                     input logic [10:0] e_pc, input logic e_push, input logic e_pop,
                     input logic [4:0] e_d, input logic [1:0] e_s, input logic e_f);
      cyc(1'b0, 1'b1, 1'b1, o, tg, zf, sdi, e_pc, e_push, e_pop, e_d, e_s, e_f);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m = exp_q.pop_front();
         tests++;
         if (pc !== m.pc || stk_push !== m.push || stk_pop !== m.pop ||
             stk_data_out !== (m.pc + 11'd1) || depth !== m.depth ||
             state !== m.state || fault !== m.fault) begin
            fails++;
            $display("FAIL step%0d got pc=%h push=%b pop=%b dout=%h depth=%0d state=%0d fault=%b want pc=%h push=%b pop=%b dout=%h depth=%0d state=%0d fault=%b",
                     m.tag, pc, stk_push, stk_pop, stk_data_out, depth, state, fault,
                     m.pc, m.push, m.pop, m.pc + 11'd1, m.depth, m.state, m.fault);
         end
      end
   end

   initial begin
      // reset, then NOP x3
      cyc(1, 0, 0, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
      ex(OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h001, 0, 0, 0, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h002, 0, 0, 0, ST_RUN, 0);
      // single CALL / RET
      ex(OP_JMP, 11'h010, 0, 0, 11'h003, 0, 0, 0, ST_RUN, 0);
      ex(OP_CALL, 11'h100, 0, 0, 11'h010, 1, 0, 0, ST_RUN, 0);
      ex(OP_RET, 0, 0, 11'h011, 11'h100, 0, 1, 1, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h011, 0, 0, 0, ST_RUN, 0);
      // nested CALL x3, RET x3
      ex(OP_JMP, 11'h000, 0, 0, 11'h012, 0, 0, 0, ST_RUN, 0);
      ex(OP_CALL, 11'h020, 0, 0, 11'h000, 1, 0, 0, ST_RUN, 0);
      ex(OP_CALL, 11'h040, 0, 0, 11'h020, 1, 0, 1, ST_RUN, 0);
      ex(OP_CALL, 11'h060, 0, 0, 11'h040, 1, 0, 2, ST_RUN, 0);
      ex(OP_RET, 0, 0, 11'h041, 11'h060, 0, 1, 3, ST_RUN, 0);
      ex(OP_RET, 0, 0, 11'h021, 11'h041, 0, 1, 2, ST_RUN, 0);
      ex(OP_RET, 0, 0, 11'h001, 11'h021, 0, 1, 1, ST_RUN, 0);
      // BRZ both ways, stalls, pause/resume
      ex(OP_BRZ, 11'h050, 0, 0, 11'h001, 0, 0, 0, ST_RUN, 0);
      ex(OP_BRZ, 11'h050, 1, 0, 11'h002, 0, 0, 0, ST_RUN, 0);
      cyc(0, 1, 0, OP_CALL, 11'h070, 0, 0, 11'h050, 0, 0, 0, ST_RUN, 0);
      cyc(0, 1, 0, OP_RET, 0, 0, 11'h033, 11'h050, 0, 0, 0, ST_RUN, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h050, 0, 0, 0, ST_RUN, 0);
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h050, 0, 0, 0, ST_IDLE, 0);
      ex(OP_NOP, 0, 0, 0, 11'h050, 0, 0, 0, ST_RUN, 0);
      // CALL at top of address space pushes 000
      ex(OP_JMP, 11'h7FF, 0, 0, 11'h051, 0, 0, 0, ST_RUN, 0);
      ex(OP_CALL, 11'h123, 0, 0, 11'h7FF, 1, 0, 0, ST_RUN, 0);
      ex(OP_RET, 0, 0, 11'h000, 11'h123, 0, 1, 1, ST_RUN, 0);
      // reset cycle with RET presented in RUN: no pop
      cyc(1, 1, 1, OP_RET, 0, 0, 0, 11'h000, 0, 0, 0, ST_RUN, 0);
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
`ifdef CR_STACK_GUARD_EN
      ex(OP_RET, 0, 0, 11'h055, 11'h000, 0, 0, 0, ST_RUN, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_FAULT, 1);
      cyc(1, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_FAULT, 1);
`else
      ex(OP_RET, 0, 0, 11'h000, 11'h000, 0, 1, 0, ST_RUN, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 15, ST_RUN, 0);
      cyc(1, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 15, ST_IDLE, 0);
`endif
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
      for (int i = 0; i < 16; i++) begin
         ex(OP_CALL, 11'(i + 1), 0, 0, 11'(i), 1, 0, 5'(i), ST_RUN, 0);
      end
`ifdef CR_STACK_GUARD_EN
      ex(OP_CALL, 11'h200, 0, 0, 11'h010, 0, 0, 16, ST_RUN, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h010, 0, 0, 16, ST_FAULT, 1);
      ex(OP_JMP, 11'h300, 0, 0, 11'h010, 0, 0, 16, ST_FAULT, 1);
      cyc(1, 1, 1, OP_NOP, 0, 0, 0, 11'h010, 0, 0, 16, ST_FAULT, 1);
`else
      ex(OP_CALL, 11'h200, 0, 0, 11'h010, 1, 0, 0, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h200, 0, 0, 1, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h201, 0, 0, 1, ST_RUN, 0);
      cyc(1, 1, 1, OP_NOP, 0, 0, 0, 11'h202, 0, 0, 1, ST_RUN, 0);
`endif
      // HALT is sticky
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
      ex(OP_HALT, 0, 0, 0, 11'h000, 0, 0, 0, ST_RUN, 0);
      ex(OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_HALT, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_HALT, 0);
      ex(OP_CALL, 11'h005, 0, 0, 11'h000, 0, 0, 0, ST_HALT, 0);
      ex(OP_RET, 0, 0, 11'h044, 11'h000, 0, 0, 0, ST_HALT, 0);
      // reset asserted while a CALL is presented
      cyc(1, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_HALT, 0);
      cyc(0, 1, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);
      ex(OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_RUN, 0);
      cyc(1, 1, 1, OP_CALL, 11'h300, 0, 0, 11'h001, 0, 0, 0, ST_RUN, 0);
      cyc(0, 0, 1, OP_NOP, 0, 0, 0, 11'h000, 0, 0, 0, ST_IDLE, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
